// File: rtl/i2c_master_if.sv
// I2C master host/bus interface: request handshake, data streams, status and
// the SCL/SDA pins. The master modport is used by the controller; the slave
// modport is the view of whatever drives requests and models the bus.
interface i2c_master_if;
  logic       start_req;
  logic [6:0] slave_addr;
  logic       rw;
  logic [3:0] num_bytes;
  logic [7:0] tx_data;
  logic       tx_next;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       nack;
  logic       scl_out;
  logic       sda_out;
  logic       sda_in;

  modport master (
    input  start_req, slave_addr, rw, num_bytes, tx_data, sda_in,
    output tx_next, rx_data, rx_valid, busy, done, nack, scl_out, sda_out
  );

  modport slave (
    output start_req, slave_addr, rw, num_bytes, tx_data, sda_in,
    input  tx_next, rx_data, rx_valid, busy, done, nack, scl_out, sda_out
  );
endinterface

// File: rtl/i2c_master.sv
// Single-master I2C controller. A transaction is START, address byte, an
// optional run of write or read bytes, then STOP. SCL is push-pull with a
// fixed half period of HALF clocks; SDA changes one clock after SCL falls and
// is sampled on the last clock of each SCL-high phase.
module i2c_master #(
  parameter int unsigned HALF = 5
) (
  input logic          clk,
  input logic          n_rst,
  i2c_master_if.master bus
);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, STOP
  } state_t;

  localparam logic [7:0] RELOAD = 8'(HALF - 1);

  state_t     state_q;
  logic [7:0] cnt_q;      // half-period down counter
  logic [1:0] ph_q;       // slot: 0 = SCL low, 1 = SCL high; STOP uses 0..2
  logic [2:0] bit_q;      // bit index within the current byte, MSB first
  logic [3:0] bytes_q;    // data bytes still to transfer
  logic [7:0] sh_q;       // outgoing shift register (address, then write data)
  logic [7:0] rsh_q;      // incoming shift register
  logic       rw_q;
  logic       scl_q;
  logic       sda_q;
  logic       busy_q;
  logic       done_q;
  logic       nack_q;
  logic       tx_next_q;
  logic       rx_valid_q;
  logic [7:0] rx_data_q;

  logic seg_first;
  logic seg_last;
  logic slot_sda;

  assign seg_first = (cnt_q == RELOAD);
  assign seg_last  = (cnt_q == 8'd0);

  // SDA value to present for the slot now in its SCL-low phase.
  always_comb begin
    slot_sda = 1'b1;
    case (state_q)
      ADDR:     slot_sda = sh_q[bit_q];
      WRITE:    slot_sda = (bit_q == 3'd7) ? bus.tx_data[7] : sh_q[bit_q];
      READ_ACK: slot_sda = (bytes_q <= 4'd1);  // NACK the final byte
      default:  slot_sda = 1'b1;
    endcase
  end

  // Transaction FSM with registered bus pins, strobes and status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      ph_q       <= 2'd0;
      bit_q      <= 3'd0;
      bytes_q    <= 4'd0;
      sh_q       <= 8'd0;
      rsh_q      <= 8'd0;
      rw_q       <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      tx_next_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= 8'd0;
    end else begin
      done_q     <= 1'b0;
      tx_next_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          scl_q <= 1'b1;
          sda_q <= 1'b1;
          if (bus.start_req) begin
            state_q <= START;
            busy_q  <= 1'b1;
            nack_q  <= 1'b0;
            sh_q    <= {bus.slave_addr, bus.rw};
            rw_q    <= bus.rw;
            bytes_q <= bus.num_bytes;
            sda_q   <= 1'b0;  // START: SDA falls while SCL is high
            cnt_q   <= RELOAD;
          end
        end

        START: begin
          if (seg_last) begin
            state_q <= ADDR;
            scl_q   <= 1'b0;
            ph_q    <= 2'd0;
            bit_q   <= 3'd7;
            cnt_q   <= RELOAD;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end

        STOP: begin
          if (ph_q == 2'd0 && seg_first) sda_q <= 1'b0;
          if (!seg_last) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            cnt_q <= RELOAD;
            case (ph_q)
              2'd0: begin
                scl_q <= 1'b1;
                ph_q  <= 2'd1;
              end
              2'd1: begin
                sda_q <= 1'b1;  // STOP: SDA rises while SCL is high
                ph_q  <= 2'd2;
              end
              default: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                ph_q    <= 2'd0;
              end
            endcase
          end
        end

        default: begin
          if (ph_q == 2'd0) begin
            // SCL low: update SDA one clock in, then raise SCL
            if (seg_first) sda_q <= slot_sda;
            if (seg_first && state_q == WRITE && bit_q == 3'd7) sh_q <= bus.tx_data;
            if (seg_last) begin
              scl_q <= 1'b1;
              ph_q  <= 2'd1;
              cnt_q <= RELOAD;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end else if (!seg_last) begin
            cnt_q <= cnt_q - 8'd1;
          end else begin
            // last clock of SCL high: sda_in is sampled here, slot ends
            scl_q <= 1'b0;
            ph_q  <= 2'd0;
            cnt_q <= RELOAD;
            case (state_q)
              ADDR: begin
                if (bit_q == 3'd0) state_q <= ADDR_ACK;
                else               bit_q   <= bit_q - 3'd1;
              end
              ADDR_ACK: begin
                bit_q <= 3'd7;
                if (bus.sda_in) begin
                  nack_q  <= 1'b1;
                  state_q <= STOP;
                end else if (bytes_q == 4'd0) begin
                  state_q <= STOP;
                end else if (rw_q) begin
                  state_q <= READ;
                end else begin
                  state_q   <= WRITE;
                  tx_next_q <= 1'b1;
                end
              end
              WRITE: begin
                if (bit_q == 3'd0) state_q <= WRITE_ACK;
                else               bit_q   <= bit_q - 3'd1;
              end
              WRITE_ACK: begin
                bit_q <= 3'd7;
                if (bus.sda_in) begin
                  nack_q  <= 1'b1;
                  state_q <= STOP;
                end else begin
                  if (bytes_q != 4'd0) bytes_q <= bytes_q - 4'd1;
                  if (bytes_q <= 4'd1) begin
                    state_q <= STOP;
                  end else begin
                    state_q   <= WRITE;
                    tx_next_q <= 1'b1;
                  end
                end
              end
              READ: begin
                rsh_q <= {rsh_q[6:0], bus.sda_in};
                if (bit_q == 3'd0) begin
                  state_q    <= READ_ACK;
                  rx_data_q  <= {rsh_q[6:0], bus.sda_in};
                  rx_valid_q <= 1'b1;
                end else begin
                  bit_q <= bit_q - 3'd1;
                end
              end
              READ_ACK: begin
                bit_q <= 3'd7;
                if (bytes_q != 4'd0) bytes_q <= bytes_q - 4'd1;
                if (bytes_q <= 4'd1) state_q <= STOP;
                else                 state_q <= READ;
              end
              default: state_q <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  assign bus.scl_out  = scl_q;
  assign bus.sda_out  = sda_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.nack     = nack_q;
  assign bus.tx_next  = tx_next_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master with HALF=3 and a behavioural I2C slave that
// decodes the bus, acknowledges, serves read data and times every SCL phase.
module tb_i2c_master;
  localparam int HALF = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  i2c_master_if dif();
  i2c_master #(.HALF(HALF)) dut (.clk(clk), .n_rst(n_rst), .bus(dif));

  logic slv_sda = 1'b1;
  assign dif.sda_in = dif.sda_out & slv_sda;

  int checks = 0;
  int errors = 0;

  // slave behaviour, set by the tests
  logic       ack_addr = 1'b1;
  logic       ack_wr   = 1'b1;
  logic [7:0] rdb [0:3];
  int         n_rd = 0;
  logic [7:0] wr_tbl [0:3];

  // slave / monitor state
  int         cyc = 0;
  logic       p_scl = 1'b1, p_sdao = 1'b1, in_tx = 1'b0, rd = 1'b0, adv = 1'b0;
  int         bitn = 0, byten = 0, wr_idx = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] wrb [0:7];
  logic       mack [0:7];
  logic [7:0] rxv [0:15];
  int         ntx = 0, nrx = 0, ndone = 0, hi_chg = 0, viol = 0, nphase = 0;
  int         t_rise = 0, t_fall = 0;
  logic       tr_v = 1'b0, tf_v = 1'b0;

  // Behavioural slave and bus monitor, sampled on the falling clock edge.
  always @(negedge clk) begin
    logic scl, sdao, line;
    cyc++;
    scl  = dif.scl_out;
    sdao = dif.sda_out;
    line = sdao & slv_sda;
    if (!n_rst) begin
      in_tx = 1'b0; tr_v = 1'b0; tf_v = 1'b0; slv_sda = 1'b1; adv = 1'b0;
      dif.tx_data = wr_tbl[0];
    end else begin
      if (adv) begin wr_idx++; dif.tx_data = wr_tbl[wr_idx & 3]; adv = 1'b0; end
      if (dif.tx_next) begin ntx++; adv = 1'b1; end
      if (dif.rx_valid) begin rxv[nrx & 15] = dif.rx_data; nrx++; end
      if (dif.done) ndone++;
      if (p_scl && scl && (p_sdao != sdao)) begin
        hi_chg++;
        if (!sdao) begin
          in_tx = 1'b1; bitn = 0; byten = 0; rd = 1'b0; wr_idx = 0;
          dif.tx_data = wr_tbl[0]; t_rise = cyc; tr_v = 1'b1; tf_v = 1'b0;
        end else begin
          in_tx = 1'b0; slv_sda = 1'b1;
        end
      end else if (in_tx && !p_scl && scl) begin
        if (tf_v) begin nphase++; if (cyc - t_fall != HALF) viol++; end
        t_rise = cyc; tr_v = 1'b1;
        if (bitn < 8) begin
          if (byten == 0 || !rd) begin
            sh = {sh[6:0], line};
            if (bitn == 7) begin
              wrb[byten & 7] = sh;
              if (byten == 0) rd = line;
            end
          end
        end else if (rd && byten > 0) begin
          mack[(byten - 1) & 7] = line;
        end
        if (bitn == 8) begin bitn = 0; byten++; end else bitn++;
      end else if (in_tx && p_scl && !scl) begin
        if (tr_v) begin nphase++; if (cyc - t_rise != HALF) viol++; end
        t_fall = cyc; tf_v = 1'b1;
        if (bitn == 8) slv_sda = (byten == 0) ? !ack_addr : (rd ? 1'b1 : !ack_wr);
        else if (rd && byten > 0 && byten <= n_rd) slv_sda = rdb[(byten - 1) & 3][7 - bitn];
        else slv_sda = 1'b1;
      end
    end
    p_scl  = scl;
    p_sdao = sdao;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic start_txn(input logic [6:0] a, input logic r, input logic [3:0] n);
    dif.slave_addr = a; dif.rw = r; dif.num_bytes = n; dif.start_req = 1'b1;
    tick();
    dif.start_req = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int i = 0; i < 2000 && ndone == d0; i++) tick();
    tick();
  endtask

  task automatic test_reset();
    int d0, t0;
    dif.start_req = 1'b0; dif.slave_addr = 7'h00; dif.rw = 1'b0; dif.num_bytes = 4'd0;
    n_rst = 1'b0;
    repeat (3) tick();
    checks++; if (dif.scl_out !== 1'b1) begin errors++; $display("FAIL rst_scl: got %b want 1", dif.scl_out); end
    checks++; if (dif.sda_out !== 1'b1) begin errors++; $display("FAIL rst_sda: got %b want 1", dif.sda_out); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", dif.busy); end
    checks++; if (dif.done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", dif.done); end
    checks++; if (dif.nack !== 1'b0) begin errors++; $display("FAIL rst_nack: got %b want 0", dif.nack); end
    checks++; if (dif.tx_next !== 1'b0) begin errors++; $display("FAIL rst_tx_next: got %b want 0", dif.tx_next); end
    checks++; if (dif.rx_valid !== 1'b0) begin errors++; $display("FAIL rst_rx_valid: got %b want 0", dif.rx_valid); end
    checks++; if (dif.rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got %h want 00", dif.rx_data); end
    // first start_req right as reset releases, zero data bytes
    d0 = ndone; t0 = ntx;
    n_rst = 1'b1;
    start_txn(7'h50, 1'b0, 4'd0);
    checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL first_start_busy: got %b want 1", dif.busy); end
    checks++; if ({dif.scl_out, dif.sda_out} !== 2'b10) begin errors++; $display("FAIL first_start_pins: got %b want 10", {dif.scl_out, dif.sda_out}); end
    wait_done(d0);
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL zero_len_done: got %0d want 1", ndone - d0); end
    checks++; if (wrb[0] !== 8'hA0) begin errors++; $display("FAIL zero_len_addr: got %h want a0", wrb[0]); end
    checks++; if (ntx - t0 !== 0) begin errors++; $display("FAIL zero_len_tx_next: got %0d want 0", ntx - t0); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL zero_len_busy: got %b want 0", dif.busy); end
  endtask

  task automatic test_write();
    int d0, t0, r0;
    wr_tbl[0] = 8'hA5; d0 = ndone; t0 = ntx; r0 = nrx;
    start_txn(7'h3C, 1'b0, 4'd1);
    wait_done(d0);
    checks++; if (wrb[0] !== 8'h78) begin errors++; $display("FAIL wr_addr: got %h want 78", wrb[0]); end
    checks++; if (wrb[1] !== 8'hA5) begin errors++; $display("FAIL wr_data: got %h want a5", wrb[1]); end
    checks++; if (ntx - t0 !== 1) begin errors++; $display("FAIL wr_tx_next: got %0d want 1", ntx - t0); end
    checks++; if (nrx - r0 !== 0) begin errors++; $display("FAIL wr_rx_valid: got %0d want 0", nrx - r0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL wr_done: got %0d want 1", ndone - d0); end
    checks++; if (dif.nack !== 1'b0) begin errors++; $display("FAIL wr_nack: got %b want 0", dif.nack); end
  endtask

  task automatic test_read();
    int d0, t0, r0;
    rdb[0] = 8'h12; rdb[1] = 8'h34; n_rd = 2;
    d0 = ndone; t0 = ntx; r0 = nrx;
    start_txn(7'h3C, 1'b1, 4'd2);
    wait_done(d0);
    n_rd = 0;
    checks++; if (wrb[0] !== 8'h79) begin errors++; $display("FAIL rd_addr: got %h want 79", wrb[0]); end
    checks++; if (nrx - r0 !== 2) begin errors++; $display("FAIL rd_count: got %0d want 2", nrx - r0); end
    checks++; if (rxv[r0 & 15] !== 8'h12) begin errors++; $display("FAIL rd_byte0: got %h want 12", rxv[r0 & 15]); end
    checks++; if (rxv[(r0 + 1) & 15] !== 8'h34) begin errors++; $display("FAIL rd_byte1: got %h want 34", rxv[(r0 + 1) & 15]); end
    checks++; if (mack[0] !== 1'b0) begin errors++; $display("FAIL rd_ack0: got %b want 0", mack[0]); end
    checks++; if (mack[1] !== 1'b1) begin errors++; $display("FAIL rd_ack1: got %b want 1", mack[1]); end
    checks++; if (ntx - t0 !== 0) begin errors++; $display("FAIL rd_tx_next: got %0d want 0", ntx - t0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL rd_done: got %0d want 1", ndone - d0); end
    checks++; if (dif.nack !== 1'b0) begin errors++; $display("FAIL rd_nack: got %b want 0", dif.nack); end
  endtask

  task automatic test_addr_nack();
    int d0, t0, r0;
    ack_addr = 1'b0; d0 = ndone; t0 = ntx; r0 = nrx;
    start_txn(7'h3C, 1'b0, 4'd1);
    wait_done(d0);
    ack_addr = 1'b1;
    checks++; if (dif.nack !== 1'b1) begin errors++; $display("FAIL an_nack: got %b want 1", dif.nack); end
    checks++; if (ntx - t0 !== 0) begin errors++; $display("FAIL an_tx_next: got %0d want 0", ntx - t0); end
    checks++; if (nrx - r0 !== 0) begin errors++; $display("FAIL an_rx_valid: got %0d want 0", nrx - r0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL an_done: got %0d want 1", ndone - d0); end
  endtask

  task automatic test_write_multi();
    int d0, t0;
    wr_tbl[0] = 8'hC3; wr_tbl[1] = 8'h5A; d0 = ndone; t0 = ntx;
    start_txn(7'h21, 1'b0, 4'd2);
    checks++; if (dif.nack !== 1'b0) begin errors++; $display("FAIL nack_clear: got %b want 0", dif.nack); end
    wait_done(d0);
    checks++; if (wrb[0] !== 8'h42) begin errors++; $display("FAIL wm_addr: got %h want 42", wrb[0]); end
    checks++; if (wrb[1] !== 8'hC3) begin errors++; $display("FAIL wm_byte0: got %h want c3", wrb[1]); end
    checks++; if (wrb[2] !== 8'h5A) begin errors++; $display("FAIL wm_byte1: got %h want 5a", wrb[2]); end
    checks++; if (ntx - t0 !== 2) begin errors++; $display("FAIL wm_tx_next: got %0d want 2", ntx - t0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL wm_done: got %0d want 1", ndone - d0); end
  endtask

  task automatic test_write_nack();
    int d0, t0;
    ack_wr = 1'b0; wr_tbl[0] = 8'hF0; d0 = ndone; t0 = ntx;
    start_txn(7'h3C, 1'b0, 4'd3);
    wait_done(d0);
    ack_wr = 1'b1;
    checks++; if (dif.nack !== 1'b1) begin errors++; $display("FAIL wn_nack: got %b want 1", dif.nack); end
    checks++; if (wrb[1] !== 8'hF0) begin errors++; $display("FAIL wn_data: got %h want f0", wrb[1]); end
    checks++; if (ntx - t0 !== 1) begin errors++; $display("FAIL wn_tx_next: got %0d want 1", ntx - t0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL wn_done: got %0d want 1", ndone - d0); end
  endtask

  task automatic test_busy_guard();
    int d0, t0, r0;
    wr_tbl[0] = 8'hA5; d0 = ndone; t0 = ntx; r0 = nrx;
    start_txn(7'h3C, 1'b0, 4'd1);
    for (int i = 0; i < 500 && !(in_tx && byten == 0 && bitn >= 3); i++) tick();
    start_txn(7'h55, 1'b1, 4'd3);
    checks++; if (dif.busy !== 1'b1) begin errors++; $display("FAIL bg_busy: got %b want 1", dif.busy); end
    wait_done(d0);
    repeat (20) tick();
    checks++; if (wrb[0] !== 8'h78) begin errors++; $display("FAIL bg_addr: got %h want 78", wrb[0]); end
    checks++; if (wrb[1] !== 8'hA5) begin errors++; $display("FAIL bg_data: got %h want a5", wrb[1]); end
    checks++; if (ntx - t0 !== 1) begin errors++; $display("FAIL bg_tx_next: got %0d want 1", ntx - t0); end
    checks++; if (nrx - r0 !== 0) begin errors++; $display("FAIL bg_rx_valid: got %0d want 0", nrx - r0); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL bg_done: got %0d want 1", ndone - d0); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL bg_idle: got %b want 0", dif.busy); end
  endtask

  task automatic test_reset_mid_write();
    int d0;
    wr_tbl[0] = 8'h0F;
    start_txn(7'h3C, 1'b0, 4'd1);
    for (int i = 0; i < 800 && !(in_tx && byten == 1 && bitn == 4); i++) tick();
    checks++; if (!(in_tx && byten == 1 && bitn == 4)) begin errors++; $display("FAIL rm_reach_bit4: got byte %0d bit %0d want 1/4", byten, bitn); end
    #2; n_rst = 1'b0; #1;
    checks++; if (dif.scl_out !== 1'b1) begin errors++; $display("FAIL rm_scl: got %b want 1", dif.scl_out); end
    checks++; if (dif.sda_out !== 1'b1) begin errors++; $display("FAIL rm_sda: got %b want 1", dif.sda_out); end
    checks++; if (dif.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", dif.busy); end
    repeat (2) tick();
    n_rst = 1'b1;
    tick();
    wr_tbl[0] = 8'h96; d0 = ndone;
    start_txn(7'h3C, 1'b0, 4'd1);
    wait_done(d0);
    checks++; if (wrb[1] !== 8'h96) begin errors++; $display("FAIL rm_after_data: got %h want 96", wrb[1]); end
    checks++; if (ndone - d0 !== 1) begin errors++; $display("FAIL rm_after_done: got %0d want 1", ndone - d0); end
  endtask

  task automatic test_timing();
    int v0, p0, h0, d0;
    wr_tbl[0] = 8'h81; v0 = viol; p0 = nphase; h0 = hi_chg; d0 = ndone;
    start_txn(7'h3C, 1'b0, 4'd1);
    wait_done(d0);
    checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL tw_phase_len: got %0d bad phases want 0", viol - v0); end
    checks++; if (nphase - p0 !== 38) begin errors++; $display("FAIL tw_phase_cnt: got %0d want 38", nphase - p0); end
    checks++; if (hi_chg - h0 !== 2) begin errors++; $display("FAIL tw_sda_hi_chg: got %0d want 2", hi_chg - h0); end
    rdb[0] = 8'hC6; rdb[1] = 8'h3B; n_rd = 2;
    v0 = viol; p0 = nphase; h0 = hi_chg; d0 = ndone;
    start_txn(7'h3C, 1'b1, 4'd2);
    wait_done(d0);
    n_rd = 0;
    checks++; if (viol - v0 !== 0) begin errors++; $display("FAIL tr_phase_len: got %0d bad phases want 0", viol - v0); end
    checks++; if (nphase - p0 !== 56) begin errors++; $display("FAIL tr_phase_cnt: got %0d want 56", nphase - p0); end
    checks++; if (hi_chg - h0 !== 2) begin errors++; $display("FAIL tr_sda_hi_chg: got %0d want 2", hi_chg - h0); end
    checks++; if (rxv[(nrx - 1) & 15] !== 8'h3B) begin errors++; $display("FAIL tr_last_byte: got %h want 3b", rxv[(nrx - 1) & 15]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_write_multi();
    test_write_nack();
    test_busy_guard();
    test_reset_mid_write();
    test_timing();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
